usb_tx: RTL and testbench

USB full-speed transmit serializer: the outbound counterpart of the encryptor chip's USB receive path. It accepts packet bytes from the protocol/encryption layer over a valid/ready byte stream, then drives the downstream port's `d_plus_out`/`d_minus_out` pair. On the line it emits SYNC, the NRZI-encoded and bit-stuffed payload (LSB first), and the EOP.

---
 rtl/usb_tx.sv | 195 +++++++++++++++++++
 tb/tb_usb_tx.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/usb_tx.sv
// USB full-speed transmit serializer: SYNC, NRZI-encoded bit-stuffed payload (LSB first), EOP.
// Bytes arrive on a valid/ready stream into a one-byte holding register ahead of the shifter.
module usb_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_err,
  output logic       d_plus_out,
  output logic       d_minus_out
);

  localparam int unsigned PHASE_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned BITCNT_W  = 4;
  localparam int unsigned ONES_W    = 3;
  localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'h80;

  typedef enum logic [1:0] {S_IDLE, S_SYNC, S_DATA, S_EOP} state_e;

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [BITCNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [ONES_W-1:0]    ones_q, ones_d;
  logic [BYTE_W-1:0]    shift_q, shift_d;
  logic [BYTE_W-1:0]    hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 last_q, last_d;
  logic                 dp_q, dp_d;
  logic                 dm_q, dm_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;

  logic                 emit_en, emit_bit;
  logic                 serial_c, bound_c, stuff_c, byte_end_c, accept_c, load_c, finish_c;

  assign serial_c   = (state_q == S_SYNC) || (state_q == S_DATA);
  assign bound_c    = (state_q != S_IDLE) && (phase_q == PHASE_W'(CLKS_PER_BIT - 1));
  assign stuff_c    = (ones_q == ONES_W'(6));
  assign byte_end_c = (bitcnt_q == BITCNT_W'(8));
  assign accept_c   = tx_valid && ready_q;
  // Byte boundary with no stuff bit pending: either reload from the holding register or stop.
  assign load_c     = serial_c && bound_c && !stuff_c && byte_end_c && hold_full_q;
  assign finish_c   = serial_c && bound_c && !stuff_c && byte_end_c && !hold_full_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:         if (tx_start) state_d = S_SYNC;
      S_SYNC, S_DATA: begin
        if (load_c)        state_d = S_DATA;
        else if (finish_c) state_d = S_EOP;
      end
      S_EOP:          if (bound_c && (bitcnt_q == BITCNT_W'(2))) state_d = S_IDLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Datapath and line next-values; the line only moves on bit boundaries.
  always_comb begin
    phase_d     = phase_q;
    bitcnt_d    = bitcnt_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    dp_d        = dp_q;
    dm_d        = dm_q;
    err_d       = 1'b0;
    emit_en     = 1'b0;
    emit_bit    = 1'b0;

    if (state_q == S_IDLE) begin
      phase_d = '0;
      if (tx_start) begin
        emit_en     = 1'b1;
        emit_bit    = SYNC_BYTE[0];
        shift_d     = SYNC_BYTE >> 1;
        bitcnt_d    = BITCNT_W'(1);
        ones_d      = '0;
        hold_full_d = 1'b0;
        last_d      = 1'b0;
      end
    end else if (bound_c) begin
      phase_d = '0;
      if (serial_c) begin
        if (stuff_c) begin
          emit_en  = 1'b1;
          emit_bit = 1'b0;
        end else if (!byte_end_c) begin
          emit_en  = 1'b1;
          emit_bit = shift_q[0];
          shift_d  = shift_q >> 1;
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
        end else if (hold_full_q) begin
          emit_en     = 1'b1;
          emit_bit    = hold_q[0];
          shift_d     = hold_q >> 1;
          bitcnt_d    = BITCNT_W'(1);
          hold_full_d = 1'b0;
        end else begin
          dp_d     = 1'b0;
          dm_d     = 1'b0;
          bitcnt_d = '0;
          ones_d   = '0;
          err_d    = !last_q;
        end
      end else begin
        // EOP: SE0, SE0, then J.
        bitcnt_d = bitcnt_q + BITCNT_W'(1);
        if (bitcnt_q != '0) begin
          dp_d = 1'b1;
          dm_d = 1'b0;
        end
      end
    end else begin
      phase_d = phase_q + PHASE_W'(1);
    end

    // NRZI: a 0 toggles J<->K, a 1 holds and extends the run of ones.
    if (emit_en) begin
      if (emit_bit) begin
        ones_d = ones_q + ONES_W'(1);
      end else begin
        ones_d = '0;
        dp_d   = ~dp_q;
        dm_d   = ~dm_q;
      end
    end

    if (accept_c) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
      last_d      = tx_last;
    end
  end

  // Registered status outputs follow the next state.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    ready_d = ((state_d == S_SYNC) || (state_d == S_DATA)) && !hold_full_d && !last_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= '0;
      bitcnt_q    <= '0;
      ones_q      <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= 1'b0;
      dp_q        <= 1'b1;
      dm_q        <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      bitcnt_q    <= bitcnt_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      dp_q        <= dp_d;
      dm_q        <= dm_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      err_q       <= err_d;
    end
  end

  assign tx_ready    = ready_q;
  assign tx_busy     = busy_q;
  assign tx_err      = err_q;
  assign d_plus_out  = dp_q;
  assign d_minus_out = dm_q;

endmodule

// File: tb/tb_usb_tx.sv
// Directed bench for usb_tx: hand-derived line sequences, timing and handshake checks.
module tb_usb_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned MAXC = 400;

  logic       clk;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       tx_busy;
  logic       tx_err;
  logic       d_plus_out;
  logic       d_minus_out;

  usb_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_last    (tx_last),
    .tx_ready   (tx_ready),
    .tx_busy    (tx_busy),
    .tx_err     (tx_err),
    .d_plus_out (d_plus_out),
    .d_minus_out(d_minus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] line_log [0:MAXC];
  logic       ready_log [0:MAXC];
  logic [7:0] pkt_data [0:7];
  int busy_cycles, err_cycles, err_first, accepted, ncyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] enc(input byte c);
    if (c == "J")      return 2'b10;
    else if (c == "K") return 2'b01;
    else               return 2'b00;
  endfunction

  // Drive one packet of n bytes from pkt_data, logging the line each cycle (cycle 0 = tx_start).
  task automatic run_packet(input string tag, input int n, input logic with_last, input int restart_at);
    int idx;
    int c;
    bit seen_busy;
    idx = 0; c = 0; seen_busy = 0;
    busy_cycles = 0; err_cycles = 0; err_first = -1; accepted = 0;
    @(posedge clk); #1;
    tx_start = 1'b1;
    tx_valid = 1'b1;
    tx_data  = pkt_data[0];
    tx_last  = with_last && (n == 1);
    while (c < int'(MAXC)) begin
      @(negedge clk);
      line_log[c]  = {d_plus_out, d_minus_out};
      ready_log[c] = tx_ready;
      if (tx_busy) begin busy_cycles++; seen_busy = 1; end
      if (tx_err) begin
        if (err_first < 0) err_first = c;
        err_cycles++;
      end
      if (seen_busy && !tx_busy) break;
      if (tx_valid && tx_ready) begin idx++; accepted++; end
      @(posedge clk); #1;
      tx_start = (c + 1 == restart_at);
      tx_valid = (idx < n);
      if (idx < n) begin
        tx_data = pkt_data[idx];
        tx_last = with_last && (idx == n - 1);
      end else begin
        tx_data = 8'h00;
        tx_last = 1'b0;
      end
      c++;
    end
    ncyc = c;
    tx_valid = 1'b0;
    tx_start = 1'b0;
    tx_last  = 1'b0;
    chk({tag, "_done"}, 32'(seen_busy && !tx_busy), 32'd1);
  endtask

  // Each expected bit must hold from its first to its last clock of the bit time.
  task automatic check_line(input string tag, input string exp);
    int first;
    for (int i = 0; i < exp.len(); i++) begin
      first = 1 + i * int'(CPB);
      chk($sformatf("%s_bit%0d", tag, i),
          32'({line_log[first], line_log[first + int'(CPB) - 1]}),
          32'({enc(exp[i]), enc(exp[i])}));
    end
    chk({tag, "_busy_len"}, 32'(busy_cycles), 32'(exp.len() * int'(CPB)));
    chk({tag, "_idle_j"}, 32'(line_log[1 + exp.len() * int'(CPB)]), 32'(2'b10));
  endtask

  initial begin
    rst = 1'b1; tx_start = 1'b0; tx_data = 8'h00; tx_valid = 1'b0; tx_last = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_line", 32'({d_plus_out, d_minus_out}), 32'(2'b10));
    chk("rst_ready", 32'(tx_ready), 32'd0);
    chk("rst_busy", 32'(tx_busy), 32'd0);
    chk("rst_err", 32'(tx_err), 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single byte 0xA5.
    pkt_data[0] = 8'hA5;
    run_packet("a5", 1, 1'b1, 0);
    check_line("a5", "KJKJKJKKKJJKJJKK00J");
    chk("a5_err", 32'(err_cycles), 32'd0);
    chk("a5_ready_idle", 32'(ready_log[0]), 32'd0);
    chk("a5_ready_sync", 32'(ready_log[1]), 32'd1);
    chk("a5_ready_fall", 32'(ready_log[2]), 32'd0);
    chk("a5_accepted", 32'(accepted), 32'd1);

    // Stuffing: 0xFF.
    pkt_data[0] = 8'hFF;
    run_packet("ff", 1, 1'b1, 0);
    check_line("ff", "KJKJKJKKKKKKKJJJJ00J");
    chk("ff_err", 32'(err_cycles), 32'd0);

    // Back-to-back 4 bytes with tx_valid held high.
    pkt_data[0] = 8'h01; pkt_data[1] = 8'h02; pkt_data[2] = 8'h03; pkt_data[3] = 8'h04;
    run_packet("b2b", 4, 1'b1, 0);
    check_line("b2b", "KJKJKJKKKJKJKJKJKKJKJKJKKKJKJKJKJKKJKJKJ00J");
    chk("b2b_accepted", 32'(accepted), 32'd4);
    chk("b2b_err", 32'(err_cycles), 32'd0);
    chk("b2b_ready_rise", 32'(ready_log[33]), 32'd1);
    chk("b2b_ready_fall", 32'(ready_log[34]), 32'd0);

    // Underrun after 0x11 without tx_last.
    pkt_data[0] = 8'h11;
    run_packet("under", 1, 1'b0, 0);
    check_line("under", "KJKJKJKKKJKJJKJK00J");
    chk("under_err_cycles", 32'(err_cycles), 32'd1);
    chk("under_err_first", 32'(err_first), 32'd65);

    // tx_start pulsed during DATA is ignored.
    pkt_data[0] = 8'hA5;
    run_packet("restart", 1, 1'b1, 40);
    check_line("restart", "KJKJKJKKKJJKJJKK00J");
    chk("restart_accepted", 32'(accepted), 32'd1);

    // Reset in the middle of DATA.
    @(posedge clk); #1;
    tx_start = 1'b1; tx_valid = 1'b1; tx_data = 8'h00; tx_last = 1'b0;
    @(posedge clk); #1 tx_start = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("mid_busy_before", 32'(tx_busy), 32'd1);
    @(posedge clk); #1 rst = 1'b1; tx_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_line", 32'({d_plus_out, d_minus_out}), 32'(2'b10));
    chk("mid_rst_busy", 32'(tx_busy), 32'd0);
    chk("mid_rst_ready", 32'(tx_ready), 32'd0);
    chk("mid_rst_err", 32'(tx_err), 32'd0);
    pkt_data[0] = 8'hA5;
    run_packet("post_rst", 1, 1'b1, 0);
    check_line("post_rst", "KJKJKJKKKJJKJJKK00J");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
